// File: rtl/mips_define.sv
// Shared definitions for the MIPS pipeline blocks.
// Holds the branch predictor's 2-bit counter encodings, PC alignment and the
// per-entry control-field layout of the branch target buffer.
package mips_define;

  // 2-bit direction counter states: strongly/weakly not-taken, weakly/strongly taken
  localparam logic [1:0] BP_CTR_SNT = 2'd0;
  localparam logic [1:0] BP_CTR_WNT = 2'd1;
  localparam logic [1:0] BP_CTR_WT  = 2'd2;
  localparam logic [1:0] BP_CTR_ST  = 2'd3;

  // Instructions are word aligned; pc[1:0] never take part in index or tag
  localparam int BP_PC_ALIGN = 2;

  // Control part of a table entry. Tag and target are kept in separate arrays
  // because their widths depend on the instance parameters.
  typedef struct packed {
    logic       valid;
    logic [1:0] ctr;
  } bp_meta_t;

  // Width of the tag field for a given PC width and index width
  function automatic int bp_tag_w(input int addr_w, input int idx_w);
    return addr_w - idx_w - BP_PC_ALIGN;
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle between the pipeline and the branch predictor.
// master: pipeline side (drives fetch PC, resolved-branch update, clear)
// slave : predictor side (returns prediction, mispredict/redirect, statistics)
interface branch_predict_unit_if #(
  parameter int ADDR_W = 32,
  parameter int STAT_W = 32
);
  logic              clear;
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic              upd_uncond;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output clear, if_pc, upd_valid, upd_uncond, upd_pc, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  clear, if_pc, upd_valid, upd_uncond, upd_pc, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predict_unit_sat_ctr.sv
// bp_sat_ctr: next value of a 2-bit saturating direction counter.
// Ports: i_ctr current value, i_taken resolved direction, i_uncond j/jal/jr,
//        o_ctr next value (uncond forces strongly taken).
module bp_sat_ctr
  import mips_define::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  input  logic       i_uncond,
  output logic [1:0] o_ctr
);
  always_comb begin
    o_ctr = i_ctr;
    if (i_uncond) begin
      o_ctr = BP_CTR_ST;
    end else if (i_taken) begin
      if (i_ctr != BP_CTR_ST) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != BP_CTR_SNT) o_ctr = i_ctr - 2'd1;
    end
  end
endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped branch target buffer with 2-bit
// direction counters. IF looks up if_pc combinationally; MEM trains the table
// and receives mispredict/redirect_pc in the same cycle.
// Ports: clk, rst_n (async active-low), bp (slave side of branch_predict_unit_if:
//        clear, lookup, update, mispredict/redirect, saturating statistics).
module branch_predict_unit
  import mips_define::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32,
  parameter bit PRED_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = bp_tag_w(ADDR_W, IDX_W);

  // Register arrays: the read is combinational and clear hits every entry at once
  bp_meta_t          r_meta   [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [STAT_W-1:0] r_stat_br;
  logic [STAT_W-1:0] r_stat_mp;

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic             w_lk_taken;

  assign w_lk_idx   = bp.if_pc[IDX_W+1:2];
  assign w_lk_tag   = bp.if_pc[ADDR_W-1:IDX_W+2];
  assign w_lk_hit   = r_meta[w_lk_idx].valid && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_lk_taken = PRED_EN && w_lk_hit && r_meta[w_lk_idx].ctr[1];

  assign bp.pred_taken  = w_lk_taken;
  assign bp.pred_target = w_lk_taken ? r_target[w_lk_idx] : bp.if_pc + ADDR_W'(4);

  // ---------------- update ----------------
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_up_hit;
  logic [1:0]       w_ctr_next;
  logic             w_we;
  logic             w_tgt_we;
  bp_meta_t         w_new_meta;
  logic             w_mispredict;

  assign w_up_idx = bp.upd_pc[IDX_W+1:2];
  assign w_up_tag = bp.upd_pc[ADDR_W-1:IDX_W+2];
  assign w_up_hit = r_meta[w_up_idx].valid && (r_tag[w_up_idx] == w_up_tag);

  bp_sat_ctr u_sat_ctr (
    .i_ctr    (r_meta[w_up_idx].ctr),
    .i_taken  (bp.upd_taken),
    .i_uncond (bp.upd_uncond),
    .o_ctr    (w_ctr_next)
  );

  // A miss only allocates when taken; a not-taken hit keeps its old target
  assign w_we     = bp.upd_valid && (w_up_hit || bp.upd_taken);
  assign w_tgt_we = bp.upd_taken || bp.upd_uncond;

  always_comb begin
    w_new_meta.valid = 1'b1;
    if (w_up_hit)           w_new_meta.ctr = w_ctr_next;
    else if (bp.upd_uncond) w_new_meta.ctr = BP_CTR_ST;
    else                    w_new_meta.ctr = BP_CTR_WT;
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      localparam logic [IDX_W-1:0] LP_IDX = IDX_W'(gi);
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_meta[gi]   <= '{valid: 1'b0, ctr: BP_CTR_WNT};
          r_tag[gi]    <= '0;
          r_target[gi] <= '0;
        end else if (bp.clear) begin
          // clear beats a same-cycle allocation
          r_meta[gi].valid <= 1'b0;
        end else if (w_we && (w_up_idx == LP_IDX)) begin
          r_meta[gi] <= w_new_meta;
          r_tag[gi]  <= w_up_tag;
          if (w_tgt_we) r_target[gi] <= bp.upd_target;
        end
      end
    end
  endgenerate

  // ---------------- resolution ----------------
  assign w_mispredict = bp.upd_valid &&
                        ((bp.upd_taken != bp.upd_pred_taken) ||
                         (bp.upd_taken && (bp.upd_target != bp.upd_pred_target)));
  assign bp.mispredict  = w_mispredict;
  assign bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + ADDR_W'(4);

  // ---------------- statistics (saturating, unaffected by clear) ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_br <= '0;
      r_stat_mp <= '0;
    end else begin
      if (bp.upd_valid && (r_stat_br != '1)) r_stat_br <= r_stat_br + STAT_W'(1);
      if (w_mispredict && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + STAT_W'(1);
    end
  end

  assign bp.stat_branches    = r_stat_br;
  assign bp.stat_mispredicts = r_stat_mp;

  // pc[1:0] are deliberately ignored
  logic w_unused;
  assign w_unused = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed testbench for branch_predict_unit (ADDR_W=32, ENTRIES=16, STAT_W=4).
module tb_branch_predict_unit;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  branch_predict_unit_if #(.ADDR_W(32), .STAT_W(4)) bus ();

  branch_predict_unit #(
    .ADDR_W(32), .ENTRIES(16), .STAT_W(4), .PRED_EN(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic unc, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    bus.upd_valid       = 1'b1;
    bus.upd_uncond      = unc;
    bus.upd_pc          = pc;
    bus.upd_taken       = tk;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptk;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.upd_valid = 1'b0;
    bus.upd_uncond = 1'b0;
    bus.upd_taken = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_tk, input logic [31:0] exp_tgt);
    bus.if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_tk});
    check({tag, "_target"}, bus.pred_target, exp_tgt);
  endtask

  task automatic resolve(input string tag, input logic exp_mp, input logic [31:0] exp_rd);
    #1;
    check({tag, "_mispredict"}, {31'd0, bus.mispredict}, {31'd0, exp_mp});
    check({tag, "_redirect"}, bus.redirect_pc, exp_rd);
  endtask

  task automatic stats(input string tag, input int br, input int mp);
    check({tag, "_branches"}, {28'd0, bus.stat_branches}, br);
    check({tag, "_mispredicts"}, {28'd0, bus.stat_mispredicts}, mp);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.if_pc = '0;
    bus.upd_pc = '0;
    bus.upd_target = '0;
    bus.upd_pred_taken = 1'b0;
    bus.upd_pred_target = '0;
    idle();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state
    stats("reset", 0, 0);
    #1 check("reset_mispredict", {31'd0, bus.mispredict}, 32'd0);
    look("rst0", 32'h0000_0000, 1'b0, 32'h0000_0004);
    look("rst40", 32'h0000_0040, 1'b0, 32'h0000_0044);
    look("rstwrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

    // Allocate 0x100 -> 0x200 (ctr=2); same-cycle lookup sees no entry yet
    upd(32'h100, 1'b0, 1'b1, 32'h200, 1'b0, 32'h104);
    resolve("alloc", 1'b1, 32'h200);
    look("nobypass", 32'h100, 1'b0, 32'h104);
    step(); idle();
    look("hit", 32'h100, 1'b1, 32'h200);
    stats("alloc", 1, 1);

    // Not-taken twice: ctr 2->1->0
    upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b1, 32'h200);
    resolve("nt1", 1'b1, 32'h104);
    step(); idle();
    look("nt1", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 1'b0, 32'h200, 1'b0, 32'h104);
    resolve("nt2", 1'b0, 32'h104);
    step(); idle();
    stats("nt2", 3, 2);

    // Taken twice from ctr 0: 0->1 (still not-taken), 1->2 (taken, new target)
    upd(32'h100, 1'b0, 1'b1, 32'h300, 1'b0, 32'h104);
    resolve("tk1", 1'b1, 32'h300);
    step(); idle();
    look("tk1", 32'h100, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 1'b1, 32'h300, 1'b0, 32'h104);
    step(); idle();
    look("tk2", 32'h100, 1'b1, 32'h300);

    // Correct prediction, then right direction but wrong target
    upd(32'h100, 1'b0, 1'b1, 32'h300, 1'b1, 32'h300);
    resolve("tkok", 1'b0, 32'h300);
    step(); idle();
    upd(32'h100, 1'b0, 1'b1, 32'h340, 1'b1, 32'h300);
    resolve("badtgt", 1'b1, 32'h340);
    step(); idle();
    look("badtgt", 32'h100, 1'b1, 32'h340);
    stats("badtgt", 7, 5);

    // Aliasing: jump at 0x140 replaces slot 0
    upd(32'h140, 1'b1, 1'b1, 32'h500, 1'b0, 32'h144);
    resolve("alias", 1'b1, 32'h500);
    step(); idle();
    look("alias_old", 32'h100, 1'b0, 32'h104);
    look("alias_new", 32'h140, 1'b1, 32'h500);

    // Not-taken miss must not write
    upd(32'h180, 1'b0, 1'b0, 32'h900, 1'b0, 32'h184);
    resolve("ntmiss", 1'b0, 32'h184);
    step(); idle();
    look("ntmiss", 32'h140, 1'b1, 32'h500);
    stats("ntmiss", 9, 6);

    // clear wins over a same-cycle allocation; stats still count
    upd(32'h204, 1'b0, 1'b1, 32'h600, 1'b0, 32'h208);
    bus.clear = 1'b1;
    step(); idle();
    look("clr204", 32'h204, 1'b0, 32'h208);
    look("clr140", 32'h140, 1'b0, 32'h144);
    stats("clear", 10, 7);

    // 20 mispredicting updates: both 4-bit counters saturate at 15
    for (int i = 0; i < 20; i++) begin
      upd(32'h300, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
      step();
    end
    idle();
    stats("sat", 15, 15);
    look("presrst", 32'h300, 1'b1, 32'h700);

    // Async reset mid-cycle: effective before any clock edge
    #1 rst_n = 1'b0;
    #1;
    stats("arst", 0, 0);
    check("arst_taken", {31'd0, bus.pred_taken}, 32'd0);
    check("arst_target", bus.pred_target, 32'h304);
    step();
    rst_n = 1'b1;
    step();
    look("postrst", 32'h300, 1'b0, 32'h304);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage MIPS pipeline. It sits beside the datapath. The IF stage looks up the fetch PC in the same cycle and gets a predicted next PC. The MEM stage, where branches and jumps resolve, trains the table and gets a mispredict flag plus a redirect address. The unit also keeps saturating statistics counters readable over the debug bus.

## Interface
- ADDR_W, 32, PC / target width
- ENTRIES, 16, table depth; power of two, at least 2; IDX_W = log2(ENTRIES)
- STAT_W, 32, width of statistics counters
- PRED_EN, 1, 0 forces the static not-taken prediction (table still trains)

Reset: one clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous invalidate of all entries
- if_pc  in  ADDR_W  fetch address
- pred_taken  out  1  prediction for if_pc
- pred_target  out  ADDR_W  predicted next PC
- upd_valid  in  1  a resolved branch/jump is in MEM this cycle
- upd_uncond  in  1  resolved instruction is j/jal/jr
- upd_pc  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  actual direction
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction carried down the pipe
- upd_pred_target  in  ADDR_W  predicted next PC carried down the pipe
- mispredict  out  1  flush request for IF/ID/EXE
- redirect_pc  out  ADDR_W  correct next PC
- stat_branches  out  STAT_W  resolved-branch count
- stat_mispredicts  out  STAT_W  mispredict count

## Operation
- Entry fields: valid, tag = pc[ADDR_W-1:IDX_W+2], target[ADDR_W-1:0], ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] are ignored.
- Lookup:
  - hit = valid[idx] && tag match.
  - pred_taken = PRED_EN && hit && ctr[1].
  - pred_target = pred_taken ? target : if_pc+4, where the +4 wraps modulo 2^ADDR_W.
- Update, applied when upd_valid is high:
  - Hit, upd_uncond: ctr=3, target=upd_target.
  - Hit, conditional, taken: ctr=min(ctr+1,3), target=upd_target.
  - Hit, conditional, not taken: ctr=max(ctr-1,0); target is unchanged.
  - Miss and upd_taken: allocate, overwriting the slot. valid=1, tag and target written, ctr=3 if upd_uncond, else 2.
  - Miss and not taken: no write.
- mispredict is combinational: upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4.
- Statistics:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments when mispredict is high.
  - Both saturate at 2^STAT_W-1.
  - clear does not affect either counter.

## Timing
- Lookup has zero latency: combinational from if_pc and the table registers.
- An update written at posedge N is visible to lookups from cycle N+1.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. There is no bypass.
- clear and upd_valid in the same cycle: clear wins, so all entries end invalid. Statistics still count.
- Reset, asynchronous:
  - all valid=0, all ctr=1, targets and tags 0, stats 0.
  - Resulting outputs: pred_taken=0, pred_target=if_pc+4, mispredict=0 while upd_valid=0.
- Reset deassertion mid-stream: the table is empty and operation resumes on the next edge.
- Mispredict timing: mispredict and redirect_pc are valid in the same cycle as upd_valid. The pipeline controller flushes younger stages and loads redirect_pc at the next edge.

## Structure
- The shared package (mips_define) receives:
  - constants BP_CTR_SNT=0, BP_CTR_WNT=1, BP_CTR_WT=2, BP_CTR_ST=3;
  - the entry field layout.
- One sub-module, bp_sat_ctr: a combinational 2-bit next-counter function given the current value, taken and uncond.
- Table storage is a register array, not inferred RAM, because of the combinational read and the single-cycle clear.

## Test plan
- Reset, then lookups at 0x0, 0x40, 0xFFFFFFFC -> pred_taken=0; pred_target=0x4, 0x44, 0x0 (wrap).
- Conditional branch at 0x100 resolves taken to 0x200 with upd_pred_taken=0 -> mispredict=1, redirect_pc=0x200, allocation with ctr=2. Next cycle, if_pc=0x100 -> pred_taken=1, pred_target=0x200.
- The same branch resolves not-taken twice:
  - First resolution: ctr goes 2->1, and if_pc=0x100 then predicts not-taken.
  - Second resolution with upd_pred_taken=0: mispredict=0.
- Aliasing: 0x100 is allocated, then 0x140 with ENTRIES=16 resolves taken -> the slot is replaced, and if_pc=0x100 now misses.
- clear asserted together with an upd_valid taken allocation -> all lookups miss next cycle; stat_branches has still incremented by 1.
- STAT_W=4, 20 mispredicting updates -> both stats hold at 15. Asserting rst_n low mid-cycle -> stats and predictions return to reset values immediately, without waiting for a clock edge.
